// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package adder_pkg;

  // Controller states of the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest operand the adder is allowed to be built with.
  localparam int ADDER_MAX_WIDTH = 32;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder: the combinational core of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first,
// through a single full adder and one registered carry.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input
// (a - b) and an 'ovf' signed-overflow output.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH must be in 2..32");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             load_s;
  logic [WIDTH-1:0] b_ld_s;
  logic             c_ld_s;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Effective B operand and initial carry seen at operand acceptance.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_ld_s = sub ? ~b : b;
    c_ld_s = sub ? 1'b1 : cin;
`else
    b_ld_s = b;
    c_ld_s = cin;
`endif
  end

  // Next-state logic: accept operands, shift one bit per RUN cycle, finish in DONE.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    load_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_BIT) begin
          // Last bit: the bits in flight are the sign bits of a, b-effective and sum.
          state_d = DONE;
          cout_d  = fa_co;
          ovf_d   = ~(a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ fa_s);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (start) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operand capture shared by IDLE and DONE; sum/cout stay held until RUN.
    if (load_s) begin
      state_d = RUN;
      a_sh_d  = a;
      b_sh_d  = b_ld_s;
      carry_d = c_ld_s;
      cnt_d   = {CW{1'b0}};
    end else begin
      cnt_d   = cnt_d;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDER_SUB_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         CLK;
  logic         RST_N;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         cout_o;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub_i;
  logic         ovf_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start_i),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
    .ovf   (ovf_o),
`endif
    .busy  (busy_o),
    .done  (done_o),
    .sum   (sum_o),
    .cout  (cout_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: true integer result of a + b + cin (or a - b).
  function automatic longint model_raw(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    if (msub) return longint'(ma) + ((longint'(1) << W) - 1 - longint'(mb)) + 1;
    else      return longint'(ma) + longint'(mb) + longint'(mcin);
  endfunction

  function automatic logic [W-1:0] model_sum(input longint r);
    return W'(r % (longint'(1) << W));
  endfunction

  function automatic logic model_cout(input longint r);
    return (r >= (longint'(1) << W));
  endfunction

  function automatic longint sx(input logic [W-1:0] v);
    if (v[W-1]) return longint'(v) - (longint'(1) << W);
    else        return longint'(v);
  endfunction

  // Signed overflow: the signed result does not fit in W bits.
  function automatic logic model_ovf(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                     input logic mcin, input logic msub);
    longint r;
    if (msub) r = sx(ma) - sx(mb);
    else      r = sx(ma) + sx(mb) + longint'(mcin);
    return (r > (longint'(1) << (W-1)) - 1) || (r < -(longint'(1) << (W-1)));
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts cycles incl. acceptance.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tcin, input logic tsub,
                       output int lat, output int bcnt);
    int n;
    @(posedge CLK); #1;
    a_i = ta; b_i = tb_v; cin_i = tcin; start_i = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub_i = tsub;
`else
    if (tsub) $display("note: sub requested in add-only build");
`endif
    @(posedge CLK); #1;
    start_i = 1'b0;
    a_i = ~ta; b_i = ~tb_v; cin_i = ~tcin;
    n = 1; bcnt = 0;
    while (done_o !== 1'b1 && n <= 4*W) begin
      if (busy_o === 1'b1) bcnt++;
      @(posedge CLK); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic test_reset();
    RST_N = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_i = 1'b0;
`endif
    #1 RST_N = 1'b0;
    #2;
    n_checks++;
    if ({busy_o, done_o, sum_o, cout_o} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy_o, done_o, sum_o, cout_o);
    end
    start_i = 1'b1; a_i = 8'h11; b_i = 8'h22;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_holds_idle: got busy=%b, want 0", busy_o);
    end
    start_i = 1'b0;
    #2 RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, lat, bcnt);
    n_checks++;
    if (lat !== W + 1) begin
      n_fail++; $display("FAIL basic_latency: got %0d, want %0d", lat, W + 1);
    end
    n_checks++;
    if (bcnt !== W) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d, want %0d", bcnt, W);
    end
    n_checks++;
    if ({cout_o, sum_o} !== {1'b0, 8'h10} || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got sum=%h cout=%b busy=%b, want sum=10 cout=0 busy=0",
               sum_o, cout_o, busy_o);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", done_o);
    end
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({cout_o, sum_o, busy_o} !== {1'b0, 8'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_hold: got sum=%h cout=%b busy=%b, want sum=10 cout=0 busy=0",
               sum_o, cout_o, busy_o);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4] = '{8'hFF, 8'hFF, 8'h80, 8'h7F};
    logic [W-1:0] vb [4] = '{8'h01, 8'h00, 8'h80, 8'h01};
    logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat, bcnt;
    longint r;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], 1'b0, lat, bcnt);
      r = model_raw(va[i], vb[i], vc[i], 1'b0);
      n_checks++;
      if (lat !== W + 1 || sum_o !== model_sum(r) || cout_o !== model_cout(r)) begin
        n_fail++;
        $display("FAIL vector_%0d: got sum=%h cout=%b lat=%0d, want sum=%h cout=%b lat=%0d",
                 i, sum_o, cout_o, lat, model_sum(r), model_cout(r), W + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    int lat, bcnt;
    longint r;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc, 1'b0, lat, bcnt);
      r = model_raw(ra, rb, rc, 1'b0);
      n_checks++;
      if (lat !== W + 1 || sum_o !== model_sum(r) || cout_o !== model_cout(r)) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b got sum=%h cout=%b lat=%0d, want sum=%h cout=%b",
                 i, ra, rb, rc, sum_o, cout_o, lat, model_sum(r), model_cout(r));
      end
`ifdef SERIAL_ADDER_SUB_EN
      n_checks++;
      if (ovf_o !== model_ovf(ra, rb, rc, 1'b0)) begin
        n_fail++;
        $display("FAIL random_ovf_%0d: got %b, want %b", i, ovf_o, model_ovf(ra, rb, rc, 1'b0));
      end
`endif
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [W-1:0] cap_sum;
    logic         cap_cout;
    pulses = 0; cap_sum = '0; cap_cout = 1'b0;
    @(posedge CLK); #1;
    a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; start_i = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b1; start_i = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3*W; i++) begin
      if (done_o === 1'b1) begin
        pulses++; cap_sum = sum_o; cap_cout = cout_o;
      end
      @(posedge CLK); #1;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", pulses);
    end
    n_checks++;
    if ({cap_cout, cap_sum} !== {1'b0, 8'h46}) begin
      n_fail++;
      $display("FAIL ignore_start_result: got sum=%h cout=%b, want sum=46 cout=0", cap_sum, cap_cout);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge CLK); #1;
    a_i = 8'h01; b_i = 8'h01; cin_i = 1'b0; start_i = 1'b1;
    @(posedge CLK); #1;
    n = 0;
    while (done_o !== 1'b1 && n < 4*W) begin
      @(posedge CLK); #1; n++;
    end
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first_done: got timeout after %0d cycles, want done", n);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b, want busy=1 done=0", busy_o, done_o);
    end
    start_i = 1'b0;
    n = 1;
    while (done_o !== 1'b1 && n <= 4*W) begin
      @(posedge CLK); #1; n++;
    end
    n_checks++;
    if (n !== W + 1 || sum_o !== 8'h02 || cout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got sum=%h cout=%b after %0d cycles, want sum=02 cout=0 after %0d",
               sum_o, cout_o, n, W + 1);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    int lat, bcnt;
    pulses = 0;
    @(posedge CLK); #1;
    a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b1; start_i = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, done_o, sum_o, cout_o} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy_o, done_o, sum_o, cout_o);
    end
    #3 RST_N = 1'b1;
    for (int i = 0; i < 2*W; i++) begin
      @(posedge CLK); #1;
      if (done_o === 1'b1 || busy_o === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL async_reset_abort: got %0d busy/done cycles, want 0", pulses);
    end
    do_op(8'h03, 8'h04, 1'b0, 1'b0, lat, bcnt);
    n_checks++;
    if (sum_o !== 8'h07 || cout_o !== 1'b0 || lat !== W + 1) begin
      n_fail++;
      $display("FAIL async_reset_recover: got sum=%h cout=%b lat=%0d, want sum=07 cout=0 lat=%0d",
               sum_o, cout_o, lat, W + 1);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] sa [4];
    logic [W-1:0] sb [4];
    int lat, bcnt;
    longint r;
    sa[0] = 8'h05; sb[0] = 8'h07;
    sa[1] = 8'h80; sb[1] = 8'h01;
    sa[2] = W'($urandom); sb[2] = W'($urandom);
    sa[3] = W'($urandom); sb[3] = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      do_op(sa[i], sb[i], 1'b0, 1'b1, lat, bcnt);
      r = model_raw(sa[i], sb[i], 1'b0, 1'b1);
      n_checks++;
      if (sum_o !== model_sum(r) || cout_o !== model_cout(r) ||
          ovf_o !== model_ovf(sa[i], sb[i], 1'b0, 1'b1)) begin
        n_fail++;
        $display("FAIL sub_%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, sum_o, cout_o, ovf_o, model_sum(r), model_cout(r),
                 model_ovf(sa[i], sb[i], 1'b0, 1'b1));
      end
    end
    sub_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
